// File: rtl/denorm_shift_pkg.sv
// Shared sizing for the denormalising shifter, plus the clog2 / shift-overflow
// macros also used by the clz normaliser.
`ifndef DENORM_UTILS_DEFS
`define DENORM_UTILS_DEFS
`define CLOG2(x) $clog2(x)
`define SH_OVF(sh, lim) ((sh) >= (lim))
`endif

package denorm_shift_pkg;
   localparam int DS_BITS_IN   = 16;
   localparam int DS_BITS_SH   = `CLOG2(DS_BITS_IN) + 1;
   localparam int DS_FINE_BITS = 2;
endpackage

// File: rtl/denorm_shift_rshift_stage.sv
// One registered right-shift step. Amount bits below `step` are ignored, so the
// same block serves as the coarse and the fine stage. Sticky exists only with STICKY_EN.
module rshift_stage #(
   parameter int bits_in = 16,
   parameter int sh_bits = 5,
   parameter int step    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic               i_ovf,
   input  logic [sh_bits-1:0] i_amt,
   input  logic [bits_in-1:0] i_data,
`ifdef STICKY_EN
   input  logic               i_sticky,
   output logic               o_sticky,
`endif
   output logic [bits_in-1:0] o_data
);
   localparam logic [sh_bits-1:0] LOW_MASK = sh_bits'(step - 1);

   logic [sh_bits-1:0] w_amt;
   logic [bits_in-1:0] r_data;

   assign w_amt  = i_amt & ~LOW_MASK;
   assign o_data = r_data;

   always_ff @(posedge clk) begin
      if (rst)       r_data <= '0;
      else if (i_en) r_data <= i_ovf ? '0 : (i_data >> w_amt);
   end

`ifdef STICKY_EN
   logic w_lost;
   logic r_sticky;

   // Bits below the shift amount fall off the bottom.
   assign w_lost   = |(i_data & ~({bits_in{1'b1}} << w_amt));
   assign o_sticky = r_sticky;

   always_ff @(posedge clk) begin
      if (rst)       r_sticky <= 1'b0;
      else if (i_en) r_sticky <= i_sticky | (i_ovf ? |i_data : w_lost);
   end
`endif
endmodule

// File: rtl/denorm_shift.sv
// Two-stage pipelined right shifter re-inserting leading zeros, with valid/ready.
// Define STICKY_EN to add the sticky output (OR of every bit shifted out).
module denorm_shift
   import denorm_shift_pkg::*;
#(
   parameter int bits_in   = DS_BITS_IN,
   parameter int bits_sh   = DS_BITS_SH,
   parameter int fine_bits = DS_FINE_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [bits_in-1:0] b,
   input  logic [bits_sh-1:0] sh,
   input  logic               vin,
   output logic               rin,
   output logic [bits_in-1:0] pout,
   output logic               vout,
`ifdef STICKY_EN
   output logic               sticky,
`endif
   input  logic               rout
);
   localparam logic [bits_sh-1:0] LIM = bits_sh'(bits_in);

   logic                 w_stall;
   logic                 w_en;
   logic                 w_ovf;
   logic [bits_in-1:0]   w_s1_data;
   logic [bits_sh-1:0]   w_fine_amt;
   logic                 r_s1_valid;
   logic                 r_vout;
   logic                 r_s1_ovf;
   logic [fine_bits-1:0] r_s1_fine;

   // No skid buffer: upstream ready drops in the same cycle the output stalls.
   assign w_stall    = r_vout & ~rout;
   assign w_en       = ~w_stall;
   assign rin        = w_en;
   assign vout       = r_vout;
   assign w_ovf      = `SH_OVF(sh, LIM);
   assign w_fine_amt = bits_sh'(r_s1_fine);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_vout     <= 1'b0;
         r_s1_ovf   <= 1'b0;
         r_s1_fine  <= '0;
      end else if (w_en) begin
         r_s1_valid <= vin;
         r_vout     <= r_s1_valid;
         r_s1_ovf   <= w_ovf;
         r_s1_fine  <= sh[fine_bits-1:0];
      end
   end

`ifdef STICKY_EN
   logic w_s1_sticky;
`endif

   rshift_stage #(.bits_in(bits_in), .sh_bits(bits_sh), .step(1 << fine_bits)) u_coarse (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_en),
      .i_ovf    (w_ovf),
      .i_amt    (sh),
      .i_data   (b),
`ifdef STICKY_EN
      .i_sticky (1'b0),
      .o_sticky (w_s1_sticky),
`endif
      .o_data   (w_s1_data)
   );

   rshift_stage #(.bits_in(bits_in), .sh_bits(bits_sh), .step(1)) u_fine (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_en),
      .i_ovf    (r_s1_ovf),
      .i_amt    (w_fine_amt),
      .i_data   (w_s1_data),
`ifdef STICKY_EN
      .i_sticky (w_s1_sticky),
      .o_sticky (sticky),
`endif
      .o_data   (pout)
   );
endmodule

// File: tb/tb_denorm_shift.sv
// Scoreboard bench for denorm_shift: the driver queues hand-computed results,
// an independent monitor compares whatever the DUT presents.
module tb_denorm_shift;
   typedef struct packed {
      logic [15:0] p;
      logic        s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] b;
   logic [4:0]  sh;
   logic        vin;
   logic        rin;
   logic [15:0] pout;
   logic        vout;
   logic        rout;
`ifdef STICKY_EN
   logic        sticky;
`endif

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_bad = 0;

   denorm_shift #(.bits_in(16), .bits_sh(5), .fine_bits(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .b      (b),
      .sh     (sh),
      .vin    (vin),
      .rin    (rin),
      .pout   (pout),
      .vout   (vout),
`ifdef STICKY_EN
      .sticky (sticky),
`endif
      .rout   (rout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Monitor: just before each posedge, compare the presented output with the queue head.
   always begin
      @(negedge clk);
      #3;
      if (!rst && vout) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL unexpected_out: got pout=%0h with nothing outstanding at %0t", pout, $time);
         end else begin
            chk("pout", {16'h0, pout}, {16'h0, exp_q[0].p});
`ifdef STICKY_EN
            chk("sticky", {31'h0, sticky}, {31'h0, exp_q[0].s});
`endif
            if (rout) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [15:0] bb, input logic [4:0] ss,
                       input logic [15:0] ep, input logic es);
      @(negedge clk);
      #1;
      b = bb; sh = ss; vin = 1'b1;
      for (int k = 0; ; k++) begin
         #1;
         if (rin) break;
         if (k > 50) begin
            n_chk++; n_bad++;
            $display("FAIL rin_timeout: rin stuck at 0, required 1");
            break;
         end
         @(negedge clk);
         #1;
      end
      exp_q.push_back('{p: ep, s: es});
   endtask

   task automatic idle();
      @(negedge clk);
      #1;
      vin = 1'b0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         #4;
         if (exp_q.size() == 0) break;
      end
      if (k == 100) begin
         n_chk++; n_bad++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   function automatic int clz16(input logic [15:0] v);
      for (int i = 15; i >= 0; i--) if (v[i]) return 15 - i;
      return 16;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; b = '0; sh = '0; vin = 1'b0; rout = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      #2;
      chk("reset_vout", {31'h0, vout}, 32'h0);
      chk("reset_pout", {16'h0, pout}, 32'h0);
      chk("reset_rin",  {31'h0, rin},  32'h1);
`ifdef STICKY_EN
      chk("reset_sticky", {31'h0, sticky}, 32'h0);
`endif

      // Identity shift, single result then bubble.
      send(16'hFFFF, 5'd0, 16'hFFFF, 1'b0);
      idle();
      drain();
      @(negedge clk); #4;
      chk("vout_one_cycle", {31'h0, vout}, 32'h0);

      // Directed shifts including overflow amounts.
      send(16'h8001, 5'd4,  16'h0800, 1'b1);
      send(16'h8000, 5'd15, 16'h0001, 1'b0);
      send(16'h00FF, 5'd16, 16'h0000, 1'b1);
      send(16'h00FF, 5'd31, 16'h0000, 1'b1);
      send(16'h0000, 5'd16, 16'h0000, 1'b0);
      send(16'hABCD, 5'd6,  16'h02AF, 1'b1);
      send(16'hF0F0, 5'd4,  16'h0F0F, 1'b0);
      idle();
      drain();

      // Back-to-back stream with a 2-cycle output stall while A is presented.
      fork
         begin
            send(16'h1234, 5'd1,  16'h091A, 1'b0);
            send(16'hF00F, 5'd8,  16'h00F0, 1'b1);
            send(16'h4000, 5'd14, 16'h0001, 1'b0);
            idle();
         end
         begin
            repeat (3) @(negedge clk);
            #1 rout = 1'b0;
            #1 chk("rin_stall0", {31'h0, rin}, 32'h0);
            @(negedge clk);
            #2 chk("rin_stall1", {31'h0, rin}, 32'h0);
            @(negedge clk);
            #1 rout = 1'b1;
            #2 chk("no_gap_a", {31'h0, vout}, 32'h1);
            @(negedge clk);
            #3 chk("no_gap_b", {31'h0, vout}, 32'h1);
            @(negedge clk);
            #3 chk("no_gap_c", {31'h0, vout}, 32'h1);
         end
      join
      drain();

      // Reset with items in flight: none of them may surface.
      @(negedge clk);
      #1 b = 16'h5555; sh = 5'd1; vin = 1'b1;
      @(negedge clk);
      #1 b = 16'h3333; sh = 5'd2; rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0; vin = 1'b0;
      #2 chk("rst_flush_vout", {31'h0, vout}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #4 chk("rst_no_output", {31'h0, vout}, 32'h0);
      end

      // Round trip: normalise in the bench, denormalise in the DUT.
      for (int i = 0; i < 256; i++) begin
         logic [15:0] v;
         int          c;
         v = 16'($urandom_range(1, 65535));
         c = clz16(v);
         send(v << c, 5'(c), v, 1'b0);
      end
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end
endmodule
